qbus_dma_master: RTL and testbench

- QBUS DMA bus-master sequencer on the FPGA side of the qdrv driver/receiver block.
- Accepts one single-word transfer request at a time from an internal client (disk/DMA engine).
- Arbitrates for the bus with DMR/DMG/SACK, runs a DATI or DATO cycle with proper setup and deskew, and times out missing RPLY as NXM.
- Responds to areg_block-style slaves already on the bus.

---
 rtl/qbus_dma_master_pkg.sv | 30 +++
 rtl/qbus_dma_master_if.sv | 29 ++
 rtl/qbus_dma_master_arb.sv | 52 +++++
 rtl/qbus_dma_master.sv | 149 ++++++++++++++
 tb/tb_qbus_dma_master.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/qbus_dma_master_pkg.sv
// rtl/qbus_dma_master_pkg.sv - shared states, I/O page prefix and default bus timing for the QBUS DMA master
package qbus_pkg;

  localparam int CLK_NS      = 25;
  localparam int ASETUP_DEF  = 6;
  localparam int DSETUP_DEF  = 4;
  localparam int DESKEW_DEF  = 6;
  localparam int TIMEOUT_DEF = 400;
  localparam int TW_DEF      = 9;

  localparam logic [8:0] IOPAGE_PREFIX = 9'o777;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_SYNC,
    S_DATA,
    S_RPLY_WAIT,
    S_DESKEW,
    S_RPLY_NEG,
    S_END
  } qbus_state_e;

  // BS7 marks the top 8 KB of the 22-bit space (I/O page)
  function automatic logic is_iopage(input logic [21:0] a);
    return a[21:13] == IOPAGE_PREFIX;
  endfunction

endpackage

// File: rtl/qbus_dma_master_if.sv
// rtl/qbus_dma_master_if.sv - client request port and QBUS driver/receiver strobes of the DMA master
interface qbus_dma_master_if;
  logic        req;
  logic        wr;
  logic [21:0] addr;
  logic [15:0] wdata;
  logic [1:0]  bmask;
  logic        busy;
  logic        done;
  logic        nxm;
  logic [15:0] rdata;
  logic        DALtx;
  logic        RSYNC, RRPLY, RDMGI, RINIT;
  logic        TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT, TBS7, TWTBT;

  modport master (
    input  req, wr, addr, wdata, bmask,
    input  RSYNC, RRPLY, RDMGI, RINIT,
    output busy, done, nxm, rdata, DALtx,
    output TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT, TBS7, TWTBT
  );

  modport slave (
    output req, wr, addr, wdata, bmask,
    output RSYNC, RRPLY, RDMGI, RINIT,
    input  busy, done, nxm, rdata, DALtx,
    input  TDMR, TSACK, TDMGO, TSYNC, TDIN, TDOUT, TBS7, TWTBT
  );
endinterface

// File: rtl/qbus_dma_master_arb.sv
// rtl/qbus_dma_master_arb.sv - DMR/DMG/SACK bus-mastership handshake and DMG daisy-chain pass-through
module qbus_arb (
  input  logic clk,
  input  logic reset_n,
  input  logic want,
  input  logic release_bus,
  input  logic idle,
  input  logic RDMGI,
  input  logic RSYNC,
  input  logic RRPLY,
  output logic granted,
  output logic TDMR,
  output logic TSACK,
  output logic TDMGO
);

  logic dmr_q, dmr_d;
  logic sack_q, sack_d;

  // take SACK only once the previous master has let go of SYNC and RPLY
  always_comb begin
    dmr_d  = dmr_q;
    sack_d = sack_q;
    if (release_bus) begin
      dmr_d  = 1'b0;
      sack_d = 1'b0;
    end else if (want && !sack_q) begin
      if (dmr_q && RDMGI && !RSYNC && !RRPLY) begin
        dmr_d  = 1'b0;
        sack_d = 1'b1;
      end else begin
        dmr_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dmr_q  <= 1'b0;
      sack_q <= 1'b0;
    end else begin
      dmr_q  <= dmr_d;
      sack_q <= sack_d;
    end
  end

  assign granted = sack_q;
  assign TDMR    = dmr_q;
  assign TSACK   = sack_q;
  assign TDMGO   = RDMGI & idle;

endmodule

// File: rtl/qbus_dma_master.sv
// rtl/qbus_dma_master.sv - single-word QBUS DATI/DATO bus-master sequencer; QBUS_DMA_BYTE_EN enables DATOB
module qbus_dma_master
  import qbus_pkg::*;
#(
  parameter int ASETUP  = ASETUP_DEF,
  parameter int DSETUP  = DSETUP_DEF,
  parameter int DESKEW  = DESKEW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = TW_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  qbus_dma_master_if.master  bus,
  inout  wire  [21:0]        DAL
);

  qbus_state_e   state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic          byte_q, byte_d;
  logic [21:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic          nxm_q, nxm_d;
  logic          granted;
  logic          addr_ph, data_ph, dal_tx;
  logic [21:0]   dal_out;
  logic          unused_bits;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    nxm_d   = nxm_q;
    case (state_q)
      S_IDLE: if (bus.req) begin
        wr_d    = bus.wr;
        addr_d  = {bus.addr[21:1], 1'b0};
        wdata_d = bus.wdata;
        byte_d  = 1'b0;
        nxm_d   = 1'b0;
        state_d = S_REQ;
`ifdef QBUS_DMA_BYTE_EN
        if (bus.wr && bus.bmask != 2'b11) begin
          byte_d    = 1'b1;
          addr_d[0] = (bus.bmask == 2'b10);
          if (bus.bmask == 2'b00) state_d = S_END;
        end
`endif
      end
      S_REQ: if (granted) begin
        state_d = S_ADDR;
        cnt_d   = '0;
      end
      S_ADDR: if (cnt_q == TW'(ASETUP - 1)) state_d = S_SYNC;
              else cnt_d = cnt_q + 1'b1;
      S_SYNC: begin
        cnt_d   = '0;
        state_d = wr_q ? S_DATA : S_RPLY_WAIT;
      end
      S_DATA: if (cnt_q == TW'(DSETUP - 1)) begin
        cnt_d   = '0;
        state_d = S_RPLY_WAIT;
      end else cnt_d = cnt_q + 1'b1;
      S_RPLY_WAIT: if (bus.RRPLY) begin
        cnt_d   = '0;
        state_d = wr_q ? S_RPLY_NEG : S_DESKEW;
      end else if (cnt_q == TW'(TIMEOUT - 1)) begin
        nxm_d   = 1'b1;
        state_d = S_END;
      end else cnt_d = cnt_q + 1'b1;
      S_DESKEW: if (cnt_q == TW'(DESKEW - 1)) begin
        rdata_d = DAL[15:0];
        state_d = S_RPLY_NEG;
      end else cnt_d = cnt_q + 1'b1;
      S_RPLY_NEG: if (!bus.RRPLY) state_d = S_END;
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // bus INIT aborts any cycle in flight; END itself already returns to IDLE
    if (bus.RINIT && state_q != S_IDLE && state_q != S_END) begin
      state_d = S_END;
      nxm_d   = 1'b1;
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      nxm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      nxm_q   <= nxm_d;
    end
  end

  qbus_arb u_arb (
    .clk         (clk),
    .reset_n     (reset_n),
    .want        (state_q == S_REQ),
    .release_bus (state_d == S_END),
    .idle        (state_q == S_IDLE),
    .RDMGI       (bus.RDMGI),
    .RSYNC       (bus.RSYNC),
    .RRPLY       (bus.RRPLY),
    .granted     (granted),
    .TDMR        (bus.TDMR),
    .TSACK       (bus.TSACK),
    .TDMGO       (bus.TDMGO)
  );

  assign addr_ph = (state_q == S_ADDR) || (state_q == S_SYNC);
  assign data_ph = (state_q == S_DATA) || (state_q == S_RPLY_WAIT) || (state_q == S_RPLY_NEG);
  // write data stays on DAL until the slave drops RPLY
  assign dal_tx  = addr_ph || (wr_q && data_ph);
  assign dal_out = addr_ph ? addr_q : {6'b0, wdata_q};
  assign DAL     = dal_tx ? dal_out : 22'bz;

  assign bus.DALtx = dal_tx;
  assign bus.TSYNC = (state_q == S_SYNC) || data_ph || (state_q == S_DESKEW);
  assign bus.TDIN  = !wr_q && ((state_q == S_RPLY_WAIT) || (state_q == S_DESKEW));
  assign bus.TDOUT = wr_q && (state_q == S_RPLY_WAIT);
  assign bus.TBS7  = addr_ph && is_iopage(addr_q);
  assign bus.TWTBT = (addr_ph && wr_q) || (byte_q && data_ph);
  assign bus.busy  = (state_q != S_IDLE) && (state_q != S_END);
  assign bus.done  = (state_q == S_END);
  assign bus.nxm   = nxm_q;
  assign bus.rdata = rdata_q;

  assign unused_bits = ^{bus.bmask, bus.addr[0], DAL[21:16]};

endmodule

// File: tb/tb_qbus_dma_master.sv
// tb/tb_qbus_dma_master.sv - directed bench with areg-style slave model and done-time scoreboard
module tb_qbus_dma_master;
  localparam int TIMEOUT = 400;
  localparam int LIM     = 2000;

  typedef struct {
    logic        is_rd;
    logic [15:0] rdata;
    logic        nxm;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  qbus_dma_master_if bif ();
  wire [21:0] dal_w;

  qbus_dma_master dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif),
    .DAL     (dal_w)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // areg_block-style slave: two registers at 17777774 and 17777772
  logic        slv_drive = 1'b0;
  logic [15:0] slv_dal   = '0;
  logic        rrply_s   = 1'b0;
  logic [21:0] sel_addr  = '0;
  logic        slv_sync_prev = 1'b0;
  int          slv_dly   = 0;
  logic [15:0] reg74     = 16'o123456;
  logic [15:0] reg72     = 16'o000000;

  assign dal_w     = slv_drive ? {6'b0, slv_dal} : 22'bz;
  assign bif.RRPLY = rrply_s;

  always @(negedge clk) begin
    if (bif.TSYNC && !slv_sync_prev) begin
      sel_addr = dal_w;
      slv_dly  = 0;
    end
    slv_sync_prev = bif.TSYNC;
    if (!bif.TSYNC || (sel_addr[21:1] != 21'o7777776 && sel_addr[21:1] != 21'o7777775)) begin
      rrply_s   = 1'b0;
      slv_drive = 1'b0;
    end else if (bif.TDIN) begin
      slv_dal   = sel_addr[2] ? reg74 : reg72;
      slv_drive = 1'b1;
      if (slv_dly < 2) slv_dly++;
      else rrply_s = 1'b1;
    end else if (bif.TDOUT) begin
      if (!bif.TWTBT) begin
        if (sel_addr[2]) reg74 = dal_w[15:0]; else reg72 = dal_w[15:0];
      end else if (sel_addr[0]) begin
        if (sel_addr[2]) reg74[15:8] = dal_w[15:8]; else reg72[15:8] = dal_w[15:8];
      end else begin
        if (sel_addr[2]) reg74[7:0] = dal_w[7:0]; else reg72[7:0] = dal_w[7:0];
      end
      rrply_s = 1'b1;
    end else begin
      rrply_s   = 1'b0;
      slv_drive = 1'b0;
    end
  end

  // edge recorder and scoreboard pop at done
  logic        sync_prev = 1'b0, tdin_prev = 1'b0, tdout_prev = 1'b0;
  logic        sync_bs7 = 1'b0, sync_wtbt = 1'b0, dout_wtbt = 1'b0;
  logic [21:0] sync_dal = '0;
  logic [15:0] dout_dal = '0;
  int          tsync_cnt = 0, done_cnt = 0, tdin_rise = 0, done_cyc = 0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (bif.TSYNC && !sync_prev) begin
      tsync_cnt++;
      sync_bs7  = bif.TBS7;
      sync_wtbt = bif.TWTBT;
      sync_dal  = dal_w;
    end
    if (bif.TDIN && !tdin_prev) tdin_rise = cyc;
    if (bif.TDOUT && !tdout_prev) begin
      dout_wtbt = bif.TWTBT;
      dout_dal  = dal_w[15:0];
    end
    sync_prev  = bif.TSYNC;
    tdin_prev  = bif.TDIN;
    tdout_prev = bif.TDOUT;
    if (bif.done) begin
      done_cnt++;
      done_cyc = cyc;
      if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        check("nxm", {31'b0, bif.nxm}, {31'b0, mon_e.nxm});
        if (mon_e.is_rd && !mon_e.nxm) check("rdata", {16'b0, bif.rdata}, {16'b0, mon_e.rdata});
      end
    end
  end

  task automatic issue(input logic w, input logic [21:0] a, input logic [15:0] d,
                       input logic [1:0] m, input logic [15:0] er, input logic en);
    exp_t e;
    e.is_rd = !w;
    e.rdata = er;
    e.nxm   = en;
    sb.push_back(e);
    @(negedge clk);
    bif.req = 1'b1; bif.wr = w; bif.addr = a; bif.wdata = d; bif.bmask = m;
    @(negedge clk);
    bif.req = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bif.done && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'b0, bif.done}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'b0, bif.done}, 32'd0);
  endtask

  task automatic xfer(input logic w, input logic [21:0] a, input logic [15:0] d,
                      input logic [1:0] m, input logic [15:0] er, input logic en);
    issue(w, a, d, m, er, en);
    wait_done();
  endtask

  initial begin
    int ts0;
    int n;
    bif.req = 0; bif.wr = 0; bif.addr = '0; bif.wdata = '0; bif.bmask = 2'b11;
    bif.RSYNC = 0; bif.RDMGI = 0; bif.RINIT = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", {20'b0, bif.busy, bif.done, bif.nxm, bif.DALtx, bif.TDMR, bif.TSACK,
                         bif.TDMGO, bif.TSYNC, bif.TDIN, bif.TDOUT, bif.TBS7, bif.TWTBT}, 32'd0);
    check("reset_rdata", {16'b0, bif.rdata}, 32'd0);
    reset_n = 1'b1;
    bif.RDMGI = 1'b1;
    @(negedge clk);
    check("dmgo_pass", {31'b0, bif.TDMGO}, 32'd1);

    xfer(1'b0, 22'o17777774, 16'h0, 2'b11, 16'o123456, 1'b0);
    check("rd_bs7", {31'b0, sync_bs7}, 32'd1);
    check("rd_done_once", done_cnt, 32'd1);

    xfer(1'b1, 22'o17777774, 16'o054321, 2'b11, 16'h0, 1'b0);
    check("wr_wtbt_addr", {31'b0, sync_wtbt}, 32'd1);
    check("wr_wtbt_dout", {31'b0, dout_wtbt}, 32'd0);
    check("wr_dal_dout", {16'b0, dout_dal}, {16'b0, 16'o054321});
    xfer(1'b0, 22'o17777774, 16'h0, 2'b11, 16'o054321, 1'b0);

    xfer(1'b0, 22'o17777770, 16'h0, 2'b11, 16'h0, 1'b1);
    check("nxm_latency", done_cyc - tdin_rise, TIMEOUT);
    check("nxm_drop", {29'b0, bif.TDIN, bif.TSYNC, bif.TSACK}, 32'd0);

    bif.RDMGI = 1'b0;
    ts0 = tsync_cnt;
    issue(1'b0, 22'o17777774, 16'h0, 2'b11, 16'o054321, 1'b0);
    repeat (50) @(negedge clk);
    check("arb_dmr_held", {31'b0, bif.TDMR}, 32'd1);
    check("arb_no_sync", tsync_cnt, ts0);
    bif.RSYNC = 1'b1;
    bif.RDMGI = 1'b1;
    repeat (10) @(negedge clk);
    check("arb_sack_wait", {31'b0, bif.TSACK}, 32'd0);
    check("arb_no_dmgo", {31'b0, bif.TDMGO}, 32'd0);
    bif.RSYNC = 1'b0;
    wait_done();

    issue(1'b0, 22'o17777770, 16'h0, 2'b11, 16'h0, 1'b1);
    n = 0;
    while (!bif.TDIN && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("init_tdin_seen", {31'b0, bif.TDIN}, 32'd1);
    repeat (3) @(negedge clk);
    bif.RINIT = 1'b1;
    @(negedge clk);
    bif.RINIT = 1'b0;
    check("init_done", {31'b0, bif.done}, 32'd1);
    check("init_daltx", {31'b0, bif.DALtx}, 32'd0);
    @(negedge clk);
    xfer(1'b0, 22'o17777774, 16'h0, 2'b11, 16'o054321, 1'b0);

`ifdef QBUS_DMA_BYTE_EN
    xfer(1'b1, 22'o17777772, 16'o177000, 2'b10, 16'h0, 1'b0);
    check("byte_wtbt_dout", {31'b0, dout_wtbt}, 32'd1);
    check("byte_addr0", {31'b0, sync_dal[0]}, 32'd1);
    xfer(1'b0, 22'o17777772, 16'h0, 2'b11, 16'o177000, 1'b0);
    ts0 = tsync_cnt;
    xfer(1'b1, 22'o17777772, 16'o000777, 2'b00, 16'h0, 1'b0);
    check("byte_none_nobus", tsync_cnt, ts0);
`endif

    check("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
